bp_update_ctrl: RTL
===================

BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 SHALL have parameter S_INDEX, default 3, meaning counter-array index width; NUM_SETS = 2**S_INDEX.
REQ-002 SHALL have parameter Q_DEPTH, default 4, meaning update-queue entries (power of two, >=2).
REQ-003 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: flush  in  1  synchronous re-initialise request.
REQ-006 SHALL have ports: lookup_valid  in  1 / lookup_pc  in  32  fetch-stage prediction request.
REQ-007 SHALL have ports: pred_valid  out  1 / pred_taken  out  1  prediction result.
REQ-008 SHALL have ports: upd_valid  in  1 / upd_ready  out  1 / upd_pc  in  32 / upd_taken  in  1  resolved-branch update, valid/ready handshake.
REQ-009 SHALL have ports: arr_index  out  S_INDEX / arr_increment  out  1 / arr_decrement  out  1 / arr_reset  out  1 / arr_out  in  2  drive of the shared 2-bit counter array.
REQ-010 SHALL have port busy  out  1, high while initialising.

Function
REQ-011 SHALL run FSM states INIT and RUN; INIT sweeps arr_index 0..NUM_SETS-1, one entry per cycle with arr_reset=1.
REQ-012 SHALL move INIT->RUN on the cycle after index NUM_SETS-1 is written; RUN->INIT on flush=1.
REQ-013 SHALL, on flush, clear the queue, restart the sweep at index 0, and ignore same-cycle lookup and update.
REQ-014 SHALL compute index = pc[S_INDEX+1:2] for both lookups and updates.
REQ-015 SHALL, in RUN with lookup_valid=1, drive arr_index from lookup_pc and set pred_valid=1, pred_taken=arr_out[1] combinationally (zero latency).
REQ-016 SHALL hold pred_valid=0 in INIT regardless of lookup_valid.
REQ-017 SHALL accept an update when upd_valid & upd_ready; upd_ready = RUN & queue not full (full blocks even if a pop occurs that cycle).
REQ-018 SHALL enqueue {index, taken}, index computed at acceptance.
REQ-019 SHALL give lookups priority on the shared index port; drain one queue entry per cycle only when RUN, lookup_valid=0, queue non-empty.
REQ-020 SHALL, on drain, drive arr_index=entry index, arr_increment=taken, arr_decrement=!taken, and pop in that cycle; saturation is left to the array.
REQ-021 SHALL never assert more than one of arr_reset, arr_increment, arr_decrement per cycle.
REQ-022 SHALL allow simultaneous enqueue and drain of different entries; queue pointers wrap modulo Q_DEPTH, FIFO order preserved.
REQ-023 SHALL hold arr_index=0 with all array strobes low when idle in RUN.

Reset
REQ-024 SHALL, on reset low, asynchronously enter INIT with sweep index 0, queue empty, busy=1, upd_ready=0, pred_valid=0.
REQ-025 SHALL begin the sweep on the first clk edge after reset deasserts; reset mid-sweep or mid-drain restarts from index 0 and discards queued updates.

Configuration
REQ-026 SHALL support macro BP_GSHARE_EN: when defined, keep an S_INDEX-bit global history register, reset/flush to 0, shifted left inserting upd_taken on each accepted update, and XOR it into every computed index; when undefined, no history register exists and REQ-014 applies unchanged.

Structure
REQ-027 SHALL place the FSM state enum, queue-entry struct {index, taken}, and default parameter constants in shared package bp_pkg.
REQ-028 SHALL implement the queue as sub-module bp_upd_fifo (push/pop/full/empty, one-cycle registered storage).

Verification
REQ-029 SHALL check: reset then release -> busy=1 for 8 cycles, arr_reset pulses indices 0..7, busy=0 on cycle 9, upd_ready=1.
REQ-030 SHALL check: upd_pc=0x14, taken=1, no lookups -> next cycle arr_index=5, arr_increment=1, queue empty after.
REQ-031 SHALL check: 5 updates offered back-to-back with lookup_valid held 1 -> 4 accepted, upd_ready=0 on the 5th; lookups return pred_taken=arr_out[1] every cycle; drops lookup_valid -> 4 drains in order.
REQ-032 SHALL check: flush with 3 entries queued -> no further arr_increment/arr_decrement, sweep restarts at 0, pred_valid=0 for 8 cycles.
REQ-033 SHALL check: reset asserted at sweep index 4 -> outputs return to reset values without a clock edge, sweep restarts at 0.
REQ-034 SHALL check (BP_GSHARE_EN): updates taken,taken,not-taken from reset -> history 3'b110; lookup_pc=0x1C gives arr_index=3'b001.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared FSM state, update-queue entry and default sizes for bp_update_ctrl.
// Queue entries carry a wide index field; users narrow it to their own S_INDEX.
package bp_pkg;
    localparam int S_INDEX_DEF = 3;
    localparam int Q_DEPTH_DEF = 4;
    localparam int IDX_MAX     = 16;
    typedef enum logic {INIT, RUN} state_t;
    typedef struct packed {
        logic [IDX_MAX-1:0] index;
        logic               taken;
    } upd_entry_t;
endpackage

// File: rtl/bp_update_ctrl_if.sv
// bp_update_ctrl_if: resolved-branch update channel with valid/ready handshake.
interface bp_update_ctrl_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic        upd_taken;
    modport master (output upd_valid, upd_pc, upd_taken, input upd_ready);
    modport slave  (input upd_valid, upd_pc, upd_taken, output upd_ready);
endinterface

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: update queue with registered storage and wrap-bit pointers.
module bp_upd_fifo import bp_pkg::*; #(
    parameter int DEPTH = Q_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  upd_entry_t din,
    output upd_entry_t dout,
    output logic       full,
    output logic       empty
);
    localparam int PW = $clog2(DEPTH);
    upd_entry_t mem [DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PW-1:0]] <= din;
    end
    assign dout  = mem[rd_ptr[PW-1:0]];
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: sweeps the 2-bit counter array on init, serves lookups, drains queued updates.
// Optional BP_GSHARE_EN folds a global taken-history register into every index.
module bp_update_ctrl import bp_pkg::*; #(
    parameter int S_INDEX = S_INDEX_DEF,
    parameter int Q_DEPTH = Q_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               lookup_valid,
    input  logic [31:0]        lookup_pc,
    output logic               pred_valid,
    output logic               pred_taken,
    bp_update_ctrl_if.slave    upd,
    output logic [S_INDEX-1:0] arr_index,
    output logic               arr_increment,
    output logic               arr_decrement,
    output logic               arr_reset,
    input  logic [1:0]         arr_out,
    output logic               busy
);
    state_t state, state_nx;
    logic [S_INDEX-1:0] sweep, sweep_nx, lk_idx, up_idx;
    logic full, empty, accept, drain;
    upd_entry_t head, entry;
`ifdef BP_GSHARE_EN
    logic [S_INDEX-1:0] ghr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ghr <= '0;
        else if (flush) ghr <= '0;
        else if (accept) ghr <= S_INDEX'({ghr, upd.upd_taken});
    end
    assign lk_idx = S_INDEX'(lookup_pc >> 2) ^ ghr;
    assign up_idx = S_INDEX'(upd.upd_pc >> 2) ^ ghr;
`else
    assign lk_idx = S_INDEX'(lookup_pc >> 2);
    assign up_idx = S_INDEX'(upd.upd_pc >> 2);
`endif
    assign entry = '{index: IDX_MAX'(up_idx), taken: upd.upd_taken};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            sweep <= '0;
        end else begin
            state <= state_nx;
            sweep <= sweep_nx;
        end
    end
    always_comb begin
        state_nx = flush ? INIT : (state == INIT && sweep == '1) ? RUN : state;
        sweep_nx = (flush || state == RUN) ? '0 : sweep + S_INDEX'(1);
    end
    // Lookups own the index port; the queue drains only in otherwise idle RUN cycles.
    always_comb begin
        busy          = state == INIT;
        arr_reset     = state == INIT;
        pred_valid    = state == RUN && lookup_valid && !flush;
        pred_taken    = pred_valid && arr_out >= 2'd2;
        upd.upd_ready = state == RUN && !full && !flush;
        accept        = upd.upd_valid && upd.upd_ready;
        drain         = state == RUN && !flush && !lookup_valid && !empty;
        arr_increment = drain && head.taken;
        arr_decrement = drain && !head.taken;
        arr_index     = busy ? sweep : pred_valid ? lk_idx : drain ? S_INDEX'(head.index) : '0;
    end
    bp_upd_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (accept),
        .pop   (drain),
        .din   (entry),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
endmodule
